// File: rtl/button_pkg.sv
// Shared types for the push-button conditioner.
// Channel FSM states plus a sizing helper for the per-channel counter.
package button_pkg;

    typedef enum logic [2:0] {
        RELEASED,
        PRESS_DB,
        PRESSED,
        REPEAT,
        RELEASE_DB
    } btn_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, debounce/hold FSM, shared counter.
// Input is already polarity-normalised (1 = pressed).
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic clockIn,
    input  logic resetN,
    input  logic pressedAsync,
    output logic buttonLevel,
    output logic pressPulse,
    output logic releasePulse,
    output logic repeatPulse
);

    localparam int CW =
        $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);
    localparam bit REP_EN = (REPEAT_CYCLES != 0);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  =
        CW'(REP_EN ? REPEAT_CYCLES - 1 : 0);

    btn_state_t      state;
    btn_state_t      stateNext;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cntNext;
    logic [1:0]      sync;
    logic            p;
    logic            levelNext;
    logic            pressNext;
    logic            releaseNext;
    logic            repeatNext;

    assign p = sync[1];

    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            sync         <= '0;
            state        <= RELEASED;
            cnt          <= '0;
            buttonLevel  <= 1'b0;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            repeatPulse  <= 1'b0;
        end else begin
            sync         <= {sync[0], pressedAsync};
            state        <= stateNext;
            cnt          <= cntNext;
            buttonLevel  <= levelNext;
            pressPulse   <= pressNext;
            releasePulse <= releaseNext;
            repeatPulse  <= repeatNext;
        end
    end

    // Counter only advances below its compare value, so it never wraps.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        unique case (state)
            RELEASED: begin
                if (p) begin
                    stateNext = PRESS_DB;
                    cntNext   = '0;
                end
            end
            PRESS_DB: begin
                if (!p) begin
                    stateNext = RELEASED;
                    cntNext   = '0;
                end else if (cnt == DB_LAST) begin
                    stateNext = PRESSED;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!p) begin
                    stateNext = RELEASE_DB;
                    cntNext   = '0;
                end else if (REP_EN) begin
                    if (cnt == HOLD_LAST) begin
                        stateNext = REPEAT;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt + CW'(1);
                    end
                end
            end
            REPEAT: begin
                if (!p) begin
                    stateNext = RELEASE_DB;
                    cntNext   = '0;
                end else if (cnt == REP_LAST) begin
                    cntNext = '0;
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end
            RELEASE_DB: begin
                if (p) begin
                    stateNext = PRESSED;
                    cntNext   = '0;
                end else if (cnt == DB_LAST) begin
                    stateNext = RELEASED;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end
            default: begin
                stateNext = RELEASED;
                cntNext   = '0;
            end
        endcase
    end

    always_comb begin
        pressNext   = (state == PRESS_DB) && p && (cnt == DB_LAST);
        releaseNext = (state == RELEASE_DB) && !p && (cnt == DB_LAST);
        repeatNext  = p && (((state == PRESSED) && REP_EN && (cnt == HOLD_LAST))
                         || ((state == REPEAT) && (cnt == REP_LAST)));
        levelNext   = (stateNext == PRESSED) || (stateNext == REPEAT)
                   || (stateNext == RELEASE_DB);
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: polarity normalisation and per-channel wiring.
// Each channel is synchronised, debounced and strobed independently.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS     = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic                   clockIn,
    input  logic                   resetN,
    input  logic [NUM_BUTTONS-1:0] buttonsRaw,
    output logic [NUM_BUTTONS-1:0] buttonLevel,
    output logic [NUM_BUTTONS-1:0] pressPulse,
    output logic [NUM_BUTTONS-1:0] releasePulse,
    output logic [NUM_BUTTONS-1:0] repeatPulse
);

    localparam logic POL = (ACTIVE_LOW != 0);

    logic [NUM_BUTTONS-1:0] pressedRaw;

    assign pressedRaw = buttonsRaw ^ {NUM_BUTTONS{POL}};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clockIn      (clockIn),
            .resetN       (resetN),
            .pressedAsync (pressedRaw[i]),
            .buttonLevel  (buttonLevel[i]),
            .pressPulse   (pressPulse[i]),
            .releasePulse (releasePulse[i]),
            .repeatPulse  (repeatPulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: expected strobes queued by stimulus,
// matched against observed strobes by an independent monitor.
module tb_button_conditioner;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] raw = 2'b11;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rls;
    logic [1:0] rpt;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int c;
        int ch;
        int k;
    } ev_t;

    ev_t q[$];

    button_conditioner #(
        .NUM_BUTTONS     (2),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clockIn      (clk),
        .resetN       (rst_n),
        .buttonsRaw   (raw),
        .buttonLevel  (lvl),
        .pressPulse   (prs),
        .releasePulse (rls),
        .repeatPulse  (rpt)
    );

    always #5 clk = ~clk;

    // cyc == index of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input int c, input int ch, input int k);
        ev_t e;
        e.c  = c;
        e.ch = ch;
        e.k  = k;
        q.push_back(e);
    endtask

    // Return at the falling edge just before rising edge e
    task automatic go(input int e);
        while (cyc < e - 1) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    // Return 2 time units after rising edge e
    task automatic wait_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h required %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // Monitor: match every observed strobe against the queue
    always begin
        logic s;
        int   idx;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < 3; k++) begin
                s = (k == K_PRESS) ? prs[ch] : (k == K_REL) ? rls[ch] : rpt[ch];
                if (s) begin
                    idx = -1;
                    for (int i = 0; i < q.size(); i++)
                        if (idx < 0 && q[i].c == cyc && q[i].ch == ch && q[i].k == k)
                            idx = i;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL strobe ch%0d kind%0d: seen at cycle %0d, required none",
                                 ch, k, cyc);
                    end else begin
                        q.delete(idx);
                    end
                end
            end
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing ch%0d kind%0d: not observed, required at cycle %0d",
                         q[i].ch, q[i].k, q[i].c);
                q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int a;
        int b;

        // Reset held while pins toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            raw = 2'(i);
            @(posedge clk);
            #1;
            chk("reset_outs", {24'd0, lvl, prs, rls, rpt}, 32'd0);
        end
        @(negedge clk);
        raw   = 2'b11;
        rst_n = 1'b1;
        a = cyc + 22;

        // Clean press and release on ch0
        go(a);
        raw[0] = 1'b0;
        expect_ev(a + 6, 0, K_PRESS);
        wait_edge(a + 5);
        chk("t2_level_before", 32'(lvl[0]), 32'd0);
        wait_edge(a + 6);
        chk("t2_level_press", 32'(lvl[0]), 32'd1);
        go(a + 10);
        raw[0] = 1'b1;
        expect_ev(a + 16, 0, K_REL);
        wait_edge(a + 15);
        chk("t2_level_rel_db", 32'(lvl[0]), 32'd1);
        wait_edge(a + 16);
        chk("t2_level_released", 32'(lvl[0]), 32'd0);
        a += 50;

        // Bounce: 3 low, 1 high, 3 low, high
        go(a);
        raw[0] = 1'b0;
        go(a + 3);
        raw[0] = 1'b1;
        go(a + 4);
        raw[0] = 1'b0;
        go(a + 7);
        raw[0] = 1'b1;
        wait_edge(a + 8);
        chk("t3_level_mid", 32'(lvl[0]), 32'd0);
        wait_edge(a + 14);
        chk("t3_level_end", 32'(lvl[0]), 32'd0);
        a += 50;

        // Auto-repeat while held for 30 cycles
        go(a);
        raw[0] = 1'b0;
        expect_ev(a + 6, 0, K_PRESS);
        for (int e = a + 16; e < a + 32; e += 3)
            expect_ev(e, 0, K_REP);
        expect_ev(a + 36, 0, K_REL);
        go(a + 30);
        raw[0] = 1'b1;
        wait_edge(a + 35);
        chk("t4_level_held", 32'(lvl[0]), 32'd1);
        wait_edge(a + 36);
        chk("t4_level_released", 32'(lvl[0]), 32'd0);
        a += 50;

        // Release glitch while pressed
        go(a);
        raw[0] = 1'b0;
        expect_ev(a + 6, 0, K_PRESS);
        go(a + 8);
        raw[0] = 1'b1;
        go(a + 10);
        raw[0] = 1'b0;
        wait_edge(a + 11);
        chk("t5_level_glitch", 32'(lvl[0]), 32'd1);
        wait_edge(a + 13);
        chk("t5_level_after", 32'(lvl[0]), 32'd1);
        go(a + 14);
        raw[0] = 1'b1;
        expect_ev(a + 20, 0, K_REL);
        wait_edge(a + 19);
        chk("t5_level_rel_db", 32'(lvl[0]), 32'd1);
        wait_edge(a + 20);
        chk("t5_level_released", 32'(lvl[0]), 32'd0);
        a += 50;

        // Two channels staggered by one cycle
        go(a);
        raw[0] = 1'b0;
        expect_ev(a + 6, 0, K_PRESS);
        go(a + 1);
        raw[1] = 1'b0;
        expect_ev(a + 7, 1, K_PRESS);
        wait_edge(a + 6);
        chk("t6_level_ch0_only", 32'(lvl), 32'd1);
        wait_edge(a + 7);
        chk("t6_level_both", 32'(lvl), 32'd3);
        go(a + 8);
        raw[0] = 1'b1;
        expect_ev(a + 14, 0, K_REL);
        go(a + 9);
        raw[1] = 1'b1;
        expect_ev(a + 15, 1, K_REL);
        wait_edge(a + 15);
        chk("t6_level_released", 32'(lvl), 32'd0);

        // Reset during press debounce aborts silently
        b = a + 20;
        go(b);
        raw[0] = 1'b0;
        go(b + 4);
        rst_n = 1'b0;
        #1;
        chk("t6_abort_outs", {24'd0, lvl, prs, rls, rpt}, 32'd0);
        raw[0] = 1'b1;
        go(b + 7);
        rst_n = 1'b1;
        wait_edge(b + 30);
        chk("t6_abort_level", 32'(lvl), 32'd0);

        wait_edge(b + 40);
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            errors++;
            $display("FAIL missing ch%0d kind%0d: not observed, required at cycle %0d",
                     q[i].ch, q[i].k, q[i].c);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
